// File: rtl/alu_pipe_flags.sv
// Handshaked ALU with registered result/flags {N,V,C,Z} and an iterative
// shift-add multiplier; a result is held until the consumer takes it.
module alu_pipe_flags #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dataout,
   output logic [3:0]       flags,
   output logic             illegal,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   localparam logic [3:0] MODE_ADD = 4'b0001;
   localparam logic [3:0] MODE_SUB = 4'b0010;
   localparam logic [3:0] MODE_AND = 4'b0011;
   localparam logic [3:0] MODE_OR  = 4'b0100;
   localparam logic [3:0] MODE_NOT = 4'b0101;
   localparam logic [3:0] MODE_ROR = 4'b0110;
   localparam logic [3:0] MODE_ROL = 4'b0111;
   localparam logic [3:0] MODE_XOR = 4'b1000;
   localparam logic [3:0] MODE_SHL = 4'b1001;
   localparam logic [3:0] MODE_SHR = 4'b1010;
   localparam logic [3:0] MODE_ASR = 4'b1011;
   localparam logic [3:0] MODE_SLT = 4'b1100;
   localparam logic [3:0] MODE_MUL = 4'b1101;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   dataout_q, dataout_d;
   logic [3:0]         flags_q, flags_d;
   logic               illegal_q, illegal_d;
   logic [SHW-1:0]     mulCount_q, mulCount_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   logic               accept;
   logic               mulSel;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     addSum;
   logic [WIDTH-1:0]   subDiff;
   logic [WIDTH-1:0]   aluResult;
   logic               aluCarry;
   logic               aluOvf;
   logic               aluIllegal;
   logic [2*WIDTH-1:0] accStep;

   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mulSel    = (mode == MODE_MUL) && (MUL_EN != 0);
   assign shamt     = op2[SHW-1:0];
   assign accStep   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   assign out_valid = out_valid_q;
   assign dataout   = dataout_q;
   assign flags     = flags_q;
   assign illegal   = illegal_q;
   assign busy      = (state_q == MUL);

   always_comb begin
      aluResult  = '0;
      aluCarry   = 1'b0;
      aluOvf     = 1'b0;
      aluIllegal = 1'b0;
      addSum     = {1'b0, op1} + {1'b0, op2};
      subDiff    = op1 - op2;
      case (mode)
         MODE_ADD: begin
            aluResult = addSum[WIDTH-1:0];
            aluCarry  = addSum[WIDTH];
            aluOvf    = (op1[WIDTH-1] == op2[WIDTH-1]) && (addSum[WIDTH-1] != op1[WIDTH-1]);
         end
         MODE_SUB: begin
            aluResult = subDiff;
            aluCarry  = (op1 < op2);
            aluOvf    = (op1[WIDTH-1] != op2[WIDTH-1]) && (subDiff[WIDTH-1] != op1[WIDTH-1]);
         end
         MODE_AND: aluResult = op1 & op2;
         MODE_OR:  aluResult = op1 | op2;
         MODE_NOT: aluResult = ~op1;
         MODE_ROR: aluResult = {op1[0], op1[WIDTH-1:1]};
         MODE_ROL: aluResult = {op1[WIDTH-2:0], op1[WIDTH-1]};
         MODE_XOR: aluResult = op1 ^ op2;
         MODE_SHL: aluResult = op1 << shamt;
         MODE_SHR: aluResult = op1 >> shamt;
         MODE_ASR: aluResult = $unsigned($signed(op1) >>> shamt);
         MODE_SLT: aluResult = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
         // Multiply is handled by the MUL state; reaching here means it is not built.
         default:  aluIllegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      dataout_d   = dataout_q;
      flags_d     = flags_q;
      illegal_d   = illegal_q;
      mulCount_d  = mulCount_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (mulSel) begin
                  state_d    = MUL;
                  mulCount_d = '0;
                  acc_d      = '0;
                  mcand_d    = {{WIDTH{1'b0}}, op1};
                  mplier_d   = op2;
               end else begin
                  out_valid_d = 1'b1;
                  dataout_d   = aluResult;
                  flags_d     = {aluResult[WIDTH-1], aluOvf, aluCarry, (aluResult == '0)};
                  illegal_d   = aluIllegal;
               end
            end
         end
         MUL: begin
            acc_d      = accStep;
            mcand_d    = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d   = mplier_q >> 1;
            mulCount_d = mulCount_q + 1'b1;
            // The last step's sum is loaded directly so the result lands on step WIDTH.
            if (mulCount_q == LAST_STEP) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               dataout_d   = accStep[WIDTH-1:0];
               flags_d     = {accStep[WIDTH-1], 1'b0, (|accStep[2*WIDTH-1:WIDTH]),
                              (accStep[WIDTH-1:0] == '0)};
               illegal_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         dataout_q   <= '0;
         flags_q     <= '0;
         illegal_q   <= 1'b0;
         mulCount_q  <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         dataout_q   <= dataout_d;
         flags_q     <= flags_d;
         illegal_q   <= illegal_d;
         mulCount_q  <= mulCount_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Directed bench for alu_pipe_flags: an arithmetic reference model plus a
// per-cycle compare of the handshake, result and flags.
module tb_alu_pipe_flags;

   localparam int WIDTH = 32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [3:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dataout;
   logic [3:0]  flags;
   logic        illegal;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acceptCount = 0;
   int acceptCyc = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
      logic        ill;
   } res_t;

   typedef struct packed {
      res_t r;
      int   due;
   } pend_t;

   pend_t pendQ[$];
   int    busyUntil = -1;
   bit    active = 0;
   bit    emitted = 0;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   alu_pipe_flags #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1),
      .op2       (op2),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dataout   (dataout),
      .flags     (flags),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Reference arithmetic straight from the mode table, using 64-bit integers.
   function automatic res_t model(logic [31:0] a, logic [31:0] b, logic [3:0] m);
      res_t            r;
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned p;
      int              sh;
      logic            c;
      logic            v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      sh = int'(b[4:0]);
      c  = 1'b0;
      v  = 1'b0;
      r.ill  = 1'b0;
      r.data = 32'd0;
      case (m)
         4'b0001: begin
            p = ua + ub;
            r.data = p[31:0];
            c = (p > 64'hFFFF_FFFF);
            v = (sa + sb > SMAX) || (sa + sb < SMIN);
         end
         4'b0010: begin
            p = ua - ub;
            r.data = p[31:0];
            c = (ua < ub);
            v = (sa - sb > SMAX) || (sa - sb < SMIN);
         end
         4'b0011: r.data = a & b;
         4'b0100: r.data = a | b;
         4'b0101: r.data = ~a;
         4'b0110: begin p = (ua >> 1) | (ua << 31); r.data = p[31:0]; end
         4'b0111: begin p = (ua << 1) | (ua >> 31); r.data = p[31:0]; end
         4'b1000: r.data = a ^ b;
         4'b1001: begin p = ua << sh; r.data = p[31:0]; end
         4'b1010: begin p = ua >> sh; r.data = p[31:0]; end
         4'b1011: begin sa = sa >>> sh; r.data = sa[31:0]; end
         4'b1100: r.data = (sa < sb) ? 32'd1 : 32'd0;
         4'b1101: begin
            p = ua * ub;
            r.data = p[31:0];
            c = ((p >> 32) != 0);
         end
         default: r.ill = 1'b1;
      endcase
      r.flags = {r.data[31], v, c, (r.data == 32'd0)};
      return r;
   endfunction

   // Compare process: model state advances on the decisions the next edge will act on.
   always @(negedge clk) begin : compareProc
      bit    expValid;
      bit    expBusy;
      bit    expReady;
      res_t  nextRes;
      pend_t entry;
      expValid = active && (pendQ.size() > 0) && (cyc >= pendQ[0].due);
      expBusy  = active && (cyc <= busyUntil);
      expReady = !expBusy && (!expValid || out_ready);
      if (active) begin
         check("out_valid", 32'(out_valid), 32'(expValid));
         check("busy", 32'(busy), 32'(expBusy));
         check("in_ready", 32'(in_ready), 32'(expReady));
         if (expValid) begin
            emitted = 1'b1;
            check("dataout", dataout, pendQ[0].r.data);
            check("flags", 32'(flags), 32'(pendQ[0].r.flags));
            check("illegal", 32'(illegal), 32'(pendQ[0].r.ill));
         end else if (!emitted) begin
            check("reset dataout", dataout, 32'd0);
            check("reset flags", 32'(flags), 32'd0);
            check("reset illegal", 32'(illegal), 32'd0);
         end
      end
      if (!rst_n) begin
         pendQ.delete();
         busyUntil = -1;
         emitted   = 1'b0;
         active    = 1'b1;
      end else if (active) begin
         if (expValid && out_ready) void'(pendQ.pop_front());
         if (in_valid && expReady) begin
            nextRes = model(op1, op2, mode);
            entry.r = nextRes;
            if (mode == 4'b1101) begin
               entry.due = cyc + 1 + WIDTH;
               busyUntil = cyc + WIDTH;
            end else begin
               entry.due = cyc + 1;
            end
            pendQ.push_back(entry);
            acceptCount++;
            acceptCyc = cyc;
         end
      end
   end

   task automatic pinModel(string name, logic [31:0] a, logic [31:0] b, logic [3:0] m,
                           logic [31:0] expData, logic [3:0] expFlags, logic expIll);
      res_t r;
      r = model(a, b, m);
      check({name, " model data"}, r.data, expData);
      check({name, " model flags"}, 32'(r.flags), 32'(expFlags));
      check({name, " model illegal"}, 32'(r.ill), 32'(expIll));
   endtask

   task automatic waitAccept(string name, bit hold);
      int startCount;
      bit got;
      startCount = acceptCount;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (acceptCount != startCount) begin
            got = 1'b1;
            break;
         end
      end
      check({name, " accepted"}, 32'(got), 32'd1);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic applyStimulus(string name, logic [31:0] a, logic [31:0] b, logic [3:0] m,
                                logic [31:0] expData, logic [3:0] expFlags, logic expIll,
                                bit hold);
      pinModel(name, a, b, m, expData, expFlags, expIll);
      op1      = a;
      op2      = b;
      mode     = m;
      in_valid = 1'b1;
      waitAccept(name, hold);
   endtask

   task automatic checkOutput(string name, logic [31:0] expData, logic [3:0] expFlags,
                              logic expIll, int expLat);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check({name, " out_valid seen"}, 32'(got), 32'd1);
      check({name, " latency"}, 32'(cyc - acceptCyc), 32'(expLat));
      check({name, " dataout"}, dataout, expData);
      check({name, " flags"}, 32'(flags), 32'(expFlags));
      check({name, " illegal"}, 32'(illegal), 32'(expIll));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stimulus
      int firstCyc;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op1       = '0;
      op2       = '0;
      mode      = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus("add wrap", 32'hFFFF_FFFF, 32'h1, 4'b0001, 32'h0, 4'b0011, 1'b0, 1'b0);
      checkOutput("add wrap", 32'h0, 4'b0011, 1'b0, 1);

      applyStimulus("sub 5-1", 32'd5, 32'd1, 4'b0010, 32'd4, 4'b0000, 1'b0, 1'b1);
      firstCyc = acceptCyc;
      applyStimulus("sub 1-2", 32'd1, 32'd2, 4'b0010, 32'hFFFF_FFFF, 4'b1010, 1'b0, 1'b0);
      check("sub back-to-back spacing", 32'(acceptCyc - firstCyc), 32'd1);
      checkOutput("sub 1-2", 32'hFFFF_FFFF, 4'b1010, 1'b0, 1);

      applyStimulus("add ovf", 32'h7FFF_FFFF, 32'h1, 4'b0001, 32'h8000_0000, 4'b1100, 1'b0, 1'b0);
      checkOutput("add ovf", 32'h8000_0000, 4'b1100, 1'b0, 1);
      applyStimulus("sub ovf", 32'h8000_0000, 32'h1, 4'b0010, 32'h7FFF_FFFF, 4'b0100, 1'b0, 1'b0);
      checkOutput("sub ovf", 32'h7FFF_FFFF, 4'b0100, 1'b0, 1);
      applyStimulus("asr 4", 32'h8000_0000, 32'd4, 4'b1011, 32'hF800_0000, 4'b1000, 1'b0, 1'b0);
      checkOutput("asr 4", 32'hF800_0000, 4'b1000, 1'b0, 1);
      applyStimulus("shl 0x23", 32'h11, 32'h23, 4'b1001, 32'h88, 4'b0000, 1'b0, 1'b0);
      checkOutput("shl 0x23", 32'h88, 4'b0000, 1'b0, 1);
      applyStimulus("shl 0", 32'hA5A5_A5A5, 32'h20, 4'b1001, 32'hA5A5_A5A5, 4'b1000, 1'b0, 1'b0);
      checkOutput("shl 0", 32'hA5A5_A5A5, 4'b1000, 1'b0, 1);
      applyStimulus("shr 31", 32'h8000_0000, 32'h1F, 4'b1010, 32'h1, 4'b0000, 1'b0, 1'b0);
      applyStimulus("ror", 32'h1, 32'h0, 4'b0110, 32'h8000_0000, 4'b1000, 1'b0, 1'b0);
      applyStimulus("rol", 32'h8000_0001, 32'h0, 4'b0111, 32'h3, 4'b0000, 1'b0, 1'b0);
      applyStimulus("slt -1<1", 32'hFFFF_FFFF, 32'h1, 4'b1100, 32'h1, 4'b0000, 1'b0, 1'b0);
      applyStimulus("slt 1<-1", 32'h1, 32'hFFFF_FFFF, 4'b1100, 32'h0, 4'b0001, 1'b0, 1'b0);
      applyStimulus("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0011, 32'h00F0_00F0, 4'b0000, 1'b0, 1'b0);
      applyStimulus("or zero", 32'h0, 32'h0, 4'b0100, 32'h0, 4'b0001, 1'b0, 1'b0);
      applyStimulus("not", 32'h0, 32'h0, 4'b0101, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0);
      applyStimulus("xor self", 32'h1234_5678, 32'h1234_5678, 4'b1000, 32'h0, 4'b0001, 1'b0, 1'b0);
      checkOutput("xor self", 32'h0, 4'b0001, 1'b0, 1);

      applyStimulus("mul 2^32", 32'h0001_0000, 32'h0001_0000, 4'b1101, 32'h0, 4'b0011, 1'b0, 1'b0);
      checkOutput("mul 2^32", 32'h0, 4'b0011, 1'b0, 33);

      applyStimulus("mul 3*5", 32'd3, 32'd5, 4'b1101, 32'd15, 4'b0000, 1'b0, 1'b0);
      op1      = 32'd2;
      op2      = 32'd3;
      mode     = 4'b0001;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("mul hold-off in_ready", 32'(in_ready), 32'd0);
         check("mul hold-off busy", 32'(busy), 32'd1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      checkOutput("mul 3*5", 32'd15, 4'b0000, 1'b0, 33);

      out_ready = 1'b0;
      applyStimulus("bp xor", 32'hAAAA_AAAA, 32'h0000_FFFF, 4'b1000, 32'hAAAA_5555, 4'b1000, 1'b0, 1'b0);
      checkOutput("bp xor", 32'hAAAA_5555, 4'b1000, 1'b0, 1);
      pinModel("bp add", 32'd2, 32'd3, 4'b0001, 32'd5, 4'b0000, 1'b0);
      op1      = 32'd2;
      op2      = 32'd3;
      mode     = 4'b0001;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp held out_valid", 32'(out_valid), 32'd1);
         check("bp held dataout", dataout, 32'hAAAA_5555);
         check("bp held flags", 32'(flags), 32'b1000);
         check("bp in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      waitAccept("bp add", 1'b0);
      checkOutput("bp add", 32'd5, 4'b0000, 1'b0, 1);
      @(negedge clk);
      check("bp single transfer", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      applyStimulus("illegal 1111", 32'h1234_5678, 32'h1, 4'b1111, 32'h0, 4'b0001, 1'b1, 1'b0);
      checkOutput("illegal 1111", 32'h0, 4'b0001, 1'b1, 1);
      applyStimulus("illegal 0000", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 32'h0, 4'b0001, 1'b1, 1'b0);
      checkOutput("illegal 0000", 32'h0, 4'b0001, 1'b1, 1);

      applyStimulus("mul reset", 32'd7, 32'd9, 4'b1101, 32'd63, 4'b0000, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post-reset busy", 32'(busy), 32'd0);
      check("post-reset out_valid", 32'(out_valid), 32'd0);
      check("post-reset flags", 32'(flags), 32'd0);
      check("post-reset dataout", dataout, 32'd0);
      @(posedge clk);
      #1;
      applyStimulus("add after reset", 32'd2, 32'd2, 4'b0001, 32'd4, 4'b0000, 1'b0, 1'b0);
      checkOutput("add after reset", 32'd4, 4'b0000, 1'b0, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
Parametrised, handshaked successor to the team's single-cycle 32-bit ALU.
- Accepts one operation per valid/ready transfer and returns a registered result with a four-bit flag vector.
- Adds an iterative shift-add multiply unit and shift-by-amount modes.
- Sits between the operand register file and the writeback stage; a result is held stable until writeback accepts it.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4, power of two)
MUL_EN, 1, 1 = multiply mode implemented; 0 = mode 1101 treated as illegal
SHW, log2(WIDTH), width of the shift amount taken from op2[SHW-1:0] (derived, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  operands and mode are valid
in_ready  out  1  block can accept an operation this cycle
op1  in  WIDTH  operand A
op2  in  WIDTH  operand B / shift amount
mode  in  4  operation select
out_valid  out  1  dataout/flags are valid
out_ready  in  1  consumer accepts the result
dataout  out  WIDTH  result
flags  out  4  {N, V, C, Z}
illegal  out  1  result came from an unsupported mode
busy  out  1  multiply in progress

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; out_valid=0, dataout=0, flags=0, illegal=0, busy=0, multiply counter=0. Reset overrides any in-flight multiply or held result; the operation is discarded and nothing is emitted.
- Accept rule: transfer occurs when in_valid && in_ready. Define in_ready = (state==IDLE) && (!out_valid || out_ready). This permits back-to-back single-cycle ops at full rate.
- Output rule: result is held while out_valid && !out_ready. It is released on out_ready; out_valid drops unless a new result loads in the same edge.
- States:
  - IDLE: on accept of a single-cycle op, load result and flags; out_valid=1 next cycle (latency 1).
  - IDLE: on accept of multiply, go to MUL; busy=1; latch operands.
  - MUL: one shift-add step per cycle for WIDTH cycles, using a 2*WIDTH accumulator. After step WIDTH, load result, set out_valid=1, busy=0, return to IDLE. Accept-to-out_valid latency is WIDTH+1 cycles.
- Modes (all results WIDTH bits):
  - 0001 add. {C,result} = op1+op2. V = signed overflow.
  - 0010 sub. result = op1-op2. C = borrow (op1<op2 unsigned). V = signed overflow.
  - 0011 and
  - 0100 or
  - 0101 not op1
  - 0110 rotate right by 1
  - 0111 rotate left by 1
  - 1000 xor
  - 1001 logical shift left by op2[SHW-1:0]
  - 1010 logical shift right by op2[SHW-1:0]
  - 1011 arithmetic shift right by op2[SHW-1:0]
  - 1100 set-less-than signed (result = 1 or 0)
  - 1101 multiply. Result = low WIDTH bits of the product. C = 1 if the high WIDTH bits are nonzero.
  - Any other mode (including 0000): result=0, illegal=1, Z=1, other flags 0. Latency 1.
- Flags are registered with the result and always describe the same result: Z = (result==0), N = result[WIDTH-1]. C and V are 0 for all modes not listed above as setting them.
- Shift amount 0 returns op1 unchanged. Bits of op2 above SHW are ignored.
- in_valid while busy: in_ready=0 and the operation is not accepted; the producer must hold it.

Test Plan:
- Add, WIDTH=32: op1=FFFFFFFF, op2=1 -> dataout=0, flags C=1 Z=1 N=0 V=0, out_valid exactly 1 cycle after accept.
- Sub, two back-to-back transfers with out_ready=1: 5-1 -> 4, flags 0000; then 1-2 -> FFFFFFFF, N=1 C=1. Both accepted on consecutive cycles.
- Overflow and shifts: 7FFFFFFF+1 -> 80000000, N=1 V=1. Arithmetic shift right of 80000000 by 4 -> F8000000. Shift left with op2=0x23 shifts by 3.
- Multiply: 00010000*00010000 -> dataout=0, C=1 Z=1, out_valid 33 cycles after accept, busy=1 throughout. Second request during busy is held off by in_ready=0.
- Backpressure: out_ready=0 for 5 cycles after a result -> dataout/flags stable, in_ready=0. Releasing out_ready gives one transfer only. Mode 1111 -> illegal=1, dataout=0.
- Reset mid-multiply: rst_n=0 at cycle 10 of a multiply -> next cycle busy=0, out_valid=0, flags=0. A new add accepted immediately after reset completes normally.
